bcd_conv_arbiter: RTL and testbench
===================================

# bcd_conv_arbiter

Shared binary-to-BCD conversion engine for the LED screen datapath. Up to N_REQ display clients (counters, sensor readouts, menu values) request conversion of an 8-bit value. A round-robin arbiter grants one client at a time to a single sequential double-dabble core, and the block returns hundreds/tens/ones digits with a per-client acknowledge. This replaces one combinational converter per client with one multi-cycle engine.

## Interface
- N_REQ, default 4: number of requesters, range 2–8.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-client request level; the client holds it until its ack.
- data  in  8*N_REQ  client values; client i uses bits [8i+7:8i].
- ack  out  N_REQ  one-cycle pulse to the served client while results are valid.
- busy  out  1  high whenever the FSM is not in IDLE.
- grant_id  out  3  index of the client being or last served.
- hundreds  out  4  BCD hundreds digit.
- tens  out  4  BCD tens digit.
- ones  out  4  BCD ones digit.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If any req bit is high, pick a winner by round-robin and latch its data (pre-scaled if configured) into the 20-bit shift register, upper 12 bits zero.
  - Load grant_id, clear the bit counter, go to SHIFT.
  - If no req bit is high, stay in IDLE.
- SHIFT: each cycle, apply double-dabble to the three BCD nibbles [11:8], [15:12], [19:16] in that order: a nibble ≥5 gets +3. Then shift the register left by 1 and increment the counter. After the 8th shift, go to DONE.
- DONE:
  - Register [19:16], [15:12], [11:8] to hundreds, tens, ones.
  - Pulse ack[grant_id] for exactly this cycle.
  - Go to IDLE.
- Round-robin: priority starts at grant_id+1 and wraps modulo N_REQ. After reset, client 0 has highest priority.
- If a client drops req mid-conversion, the conversion still completes and the ack is still issued. No abort.
- req stays high after ack: the client competes again in the next IDLE cycle at lowest priority.
- The data word is sampled only in the grant cycle. Later changes are ignored.
- Digit outputs hold their last result until the next DONE. They are never driven from the live shift register.
- Reset (asynchronous, any state, including mid-SHIFT):
  - FSM returns to IDLE and the counter clears.
  - ack=0, busy=0, grant_id=N_REQ-1 (so client 0 wins first), hundreds/tens/ones=0.
  - The in-flight request is dropped without an ack.

## Timing
- Grant edge (edge 0): leave IDLE. busy goes high after edge 0.
- Edges 1–8: the eight shifts. Edge 8 enters DONE, and the digit outputs and ack are registered valid after edge 8.
- Edge 9: return to IDLE. ack falls and busy falls.
- Latency: req high before edge 0 gives ack during the cycle after edge 8.
- Throughput: one conversion per 10 cycles under continuous load (the IDLE cycle included).
- Fairness: worst-case wait is N_REQ×10 cycles.
- Exactly one ack bit is high in any cycle, or none.

## Configuration
- SCALE_5_8_EN defined: the loaded value is (data×5)>>3.
  - Computed at 11-bit width, then truncated to 8 bits.
  - Range is 0–159 (255 gives 159).
  - This is the display's 5/8 unit scaling.
- SCALE_5_8_EN undefined: the raw 8-bit data is loaded (0–255). The scaling multiplier is not synthesized.

## Structure
- Package bcd_conv_pkg holds:
  - FSM state encoding (IDLE, SHIFT, DONE).
  - BIN_W=8, BCD_W=12, SHIFT_W=20, ITER=8.
  - The scale constants (multiplier 5, shift 3).
- Sub-module dd_step: combinational, 20-bit in to 20-bit out. It does one add-3 correction plus the shift. It is instantiated once and its output is registered each SHIFT cycle.
- The round-robin arbiter is an inline priority rotate in the top module. It is not a separate sub-module.

## Test plan
- Scaling off; req[0]=1, data0=255 → ack[0] pulses during the cycle after edge 8. hundreds=2, tens=5, ones=5. busy is high for 9 cycles.
- Scaling on; data0=255 → 1/5/9. data0=8 → 0/0/5. data0=0 → 0/0/0.
- After reset, all four req high with data 10, 20, 30, 40 and held until ack:
  - acks arrive in order 0, 1, 2, 3, 10 cycles apart.
  - Digits (scaling off) are 0/1/0, 0/2/0, 0/3/0, 0/4/0.
- Last grant=2 with req[0] and req[3] high → client 3 is served before client 0.
- Assert rst at SHIFT count 4 → immediately: busy=0, digits=0, no ack. After release, the held req is re-granted and completes normally.
- req[1] dropped 3 cycles after grant, with data1 changed mid-conversion → ack[1] is still pulsed, and the digits reflect the value latched at grant.

Source files
------------

// File: rtl/bcd_conv_pkg.sv
// Shared definitions for the bcd_conv_arbiter block: FSM encoding, datapath
// widths, and the optional 5/8 pre-scaling applied to a granted value.
// Optional feature macro: SCALE_5_8_EN (defined -> load (data*5)>>3).
package bcd_conv_pkg;

  localparam int unsigned BIN_W     = 8;
  localparam int unsigned BCD_W     = 12;
  localparam int unsigned SHIFT_W   = 20;
  localparam int unsigned ITER      = 8;
  localparam int unsigned CNT_W     = 4;

  localparam int unsigned SCALE_MUL = 5;
  localparam int unsigned SCALE_SHR = 3;
  localparam int unsigned SCALE_W   = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Value loaded into the shift register for a granted client.
  function automatic logic [BIN_W-1:0] load_value(input logic [BIN_W-1:0] raw);
`ifdef SCALE_5_8_EN
    logic [SCALE_W-1:0] prod;
    prod = SCALE_W'(raw) * SCALE_W'(SCALE_MUL);
    return BIN_W'(prod >> SCALE_SHR);
`else
    return raw;
`endif
  endfunction

endpackage

// File: rtl/dd_step.sv
// One double-dabble iteration: add-3 correction on the three BCD nibbles,
// then shift the whole 20-bit register left by one.
// Ports:
//   value      in  20  current shift register
//   next_value out 20  corrected and shifted register
module dd_step
  import bcd_conv_pkg::*;
(
  input  logic [SHIFT_W-1:0] value,
  output logic [SHIFT_W-1:0] next_value
);

  logic [SHIFT_W-1:0] adj;

  // Nibbles [11:8], [15:12], [19:16] are corrected in that order.
  always_comb begin
    adj = value;
    for (int n = 0; n < 3; n++) begin
      if (adj[BIN_W + 4*n +: 4] >= 4'd5) begin
        adj[BIN_W + 4*n +: 4] = adj[BIN_W + 4*n +: 4] + 4'd3;
      end
    end
    next_value = {adj[SHIFT_W-2:0], 1'b0};
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shared binary-to-BCD converter: round-robin arbitration among N_REQ clients
// feeding one sequential double-dabble engine (IDLE -> SHIFT x8 -> DONE).
// Optional feature macro: SCALE_5_8_EN (pre-scale loaded value by 5/8).
// Ports:
//   clk       in  1        system clock, rising edge
//   rst       in  1        asynchronous active-high reset
//   req       in  N_REQ    per-client request level, held until ack
//   data      in  8*N_REQ  client values, client i at [8i+7:8i]
//   ack       out N_REQ    one-cycle pulse to the served client with results
//   busy      out 1        high whenever the FSM is not idle
//   grant_id  out 3        client being or last served
//   hundreds  out 4        BCD hundreds digit
//   tens      out 4        BCD tens digit
//   ones      out 4        BCD ones digit
module bcd_conv_arbiter
  import bcd_conv_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic [2:0]         grant_id,
  output logic [3:0]         hundreds,
  output logic [3:0]         tens,
  output logic [3:0]         ones
);

  state_t               state;
  state_t               state_nxt;
  logic [SHIFT_W-1:0]   sreg;
  logic [SHIFT_W-1:0]   sreg_nxt;
  logic [SHIFT_W-1:0]   step_out;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [2:0]           grant_nxt;
  logic [N_REQ-1:0]     ack_nxt;
  logic                 busy_nxt;
  logic [3:0]           hundreds_nxt;
  logic [3:0]           tens_nxt;
  logic [3:0]           ones_nxt;

  logic                 any_req;
  logic                 last_shift;
  logic [2:0]           winner;
  logic [2:0]           idx;
  logic                 found;
  logic [7:0]           req_pad;
  logic [63:0]          data_pad;

  // Zero-padded to the 8-client maximum so 3-bit indices always fit.
  assign req_pad    = 8'(req);
  assign data_pad   = 64'(data);
  assign any_req    = |req;
  assign last_shift = (cnt == CNT_W'(ITER - 1));

  dd_step u_step (
    .value      (sreg),
    .next_value (step_out)
  );

  // Round-robin: scan starting one past the last grant, wrapping mod N_REQ.
  always_comb begin
    winner = grant_id;
    found  = 1'b0;
    idx    = 3'd0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = 3'((32'(grant_id) + k) % N_REQ);
      if (!found && req_pad[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values; results are captured on the final shift
  // edge so digits and ack are valid throughout the DONE cycle.
  always_comb begin
    sreg_nxt     = sreg;
    cnt_nxt      = cnt;
    grant_nxt    = grant_id;
    ack_nxt      = '0;
    busy_nxt     = (state_nxt != ST_IDLE);
    hundreds_nxt = hundreds;
    tens_nxt     = tens;
    ones_nxt     = ones;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          sreg_nxt  = {{BCD_W{1'b0}}, load_value(data_pad[{winner, 3'b000} +: BIN_W])};
          cnt_nxt   = '0;
          grant_nxt = winner;
        end
      end
      ST_SHIFT: begin
        sreg_nxt = step_out;
        cnt_nxt  = cnt + CNT_W'(1);
        if (last_shift) begin
          hundreds_nxt = step_out[19:16];
          tens_nxt     = step_out[15:12];
          ones_nxt     = step_out[11:8];
          ack_nxt      = N_REQ'(1) << grant_id;
        end
      end
      default: ;
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg     <= '0;
      cnt      <= '0;
      grant_id <= 3'(N_REQ - 1);
      ack      <= '0;
      busy     <= 1'b0;
      hundreds <= 4'd0;
      tens     <= 4'd0;
      ones     <= 4'd0;
    end else begin
      sreg     <= sreg_nxt;
      cnt      <= cnt_nxt;
      grant_id <= grant_nxt;
      ack      <= ack_nxt;
      busy     <= busy_nxt;
      hundreds <= hundreds_nxt;
      tens     <= tens_nxt;
      ones     <= ones_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
// Honours SCALE_5_8_EN the same way as the design.
module tb_bcd_conv_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0]   ack;
  logic           busy;
  logic [2:0]     grant_id;
  logic [3:0]     hundreds;
  logic [3:0]     tens;
  logic [3:0]     ones;

  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  bit  chk_en = 1'b0;

  bcd_conv_arbiter #(.N_REQ(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int scale(input int v);
`ifdef SCALE_5_8_EN
    return ((v * 5) >> 3) & 255;
`else
    return v;
`endif
  endfunction

  // Reference model: phase 0 = idle, 1..8 = converting, 9 = results valid.
  int           m_phase = 0;
  int           m_last = N - 1;
  int           m_val = 0;
  int           m_h = 0, m_t = 0, m_o = 0;
  logic [N-1:0] m_ack = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_last = N - 1; m_val = 0;
      m_h = 0; m_t = 0; m_o = 0; m_ack = '0;
    end else if (m_phase == 0) begin
      if (req != '0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (req[c] && m_phase == 0) begin
            m_last  = c;
            m_val   = scale(int'(data[8*c +: 8]));
            m_phase = 1;
          end
        end
      end
    end else if (m_phase < 9) begin
      m_phase++;
      if (m_phase == 9) begin
        m_h = m_val / 100;
        m_t = (m_val / 10) % 10;
        m_o = m_val % 10;
        m_ack = '0;
        m_ack[m_last] = 1'b1;
      end
    end else begin
      m_phase = 0;
      m_ack   = '0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", int'(ack), int'(m_ack));
      check("busy", int'(busy), (m_phase != 0) ? 1 : 0);
      check("grant_id", int'(grant_id), m_last);
      check("hundreds", int'(hundreds), m_h);
      check("tens", int'(tens), m_t);
      check("ones", int'(ones), m_o);
      check("ack_onehot", ($countones(ack) <= 1) ? 1 : 0, 1);
    end
  end

  task automatic set_data(input int i, input int v);
    data[8*i +: 8] = 8'(v);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
  endtask

  // Wait (bounded) for any ack; the acked client drops its request.
  task automatic wait_ack(output int id, output int at, output int h, output int t, output int o);
    int n;
    id = -1; at = 0; h = 0; t = 0; o = 0; n = 0;
    while (id < 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (ack != '0) begin
        for (int i = 0; i < N; i++) if (ack[i]) id = i;
        at = cyc; h = int'(hundreds); t = int'(tens); o = int'(ones);
        req[id] = 1'b0;
      end
    end
    if (id < 0) check("ack_timeout", 0, 1);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!busy) check("busy_timeout", 0, 1);
  endtask

  int id, at, h, t, o, bc, got;
  int ids[4], ats[4], hs[4], ts[4], os[4];
  int exp4[4][3];

  initial begin
`ifdef SCALE_5_8_EN
    exp4 = '{'{0,0,6}, '{0,1,2}, '{0,1,8}, '{0,2,5}};
`else
    exp4 = '{'{0,1,0}, '{0,2,0}, '{0,3,0}, '{0,4,0}};
`endif
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", int'(busy), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_grant", int'(grant_id), 3);
    check("rst_digits", int'({hundreds, tens, ones}), 0);
    #2 rst = 1'b0;

    // Single conversion of 255 by client 0.
    set_data(0, 255); req[0] = 1'b1;
    bc = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (ack[0]) begin
        got++; h = int'(hundreds); t = int'(tens); o = int'(ones);
        req[0] = 1'b0;
      end
    end
    check("t1_busy_cycles", bc, 9);
    check("t1_ack_count", got, 1);
`ifdef SCALE_5_8_EN
    check("t1_digits", h*100 + t*10 + o, 159);
`else
    check("t1_digits", h*100 + t*10 + o, 255);
`endif

    // Scaling corner values 8 and 0.
    set_data(0, 8); req[0] = 1'b1;
    wait_ack(id, at, h, t, o);
`ifdef SCALE_5_8_EN
    check("t2_val8", h*100 + t*10 + o, 5);
`else
    check("t2_val8", h*100 + t*10 + o, 8);
`endif
    set_data(0, 0); req[0] = 1'b1;
    wait_ack(id, at, h, t, o);
    check("t2_val0", h*100 + t*10 + o, 0);

    // Four simultaneous requesters after reset.
    do_reset();
    for (int i = 0; i < 4; i++) set_data(i, 10 * (i + 1));
    req = 4'hF;
    for (int k = 0; k < 4; k++) wait_ack(ids[k], ats[k], hs[k], ts[k], os[k]);
    for (int k = 0; k < 4; k++) begin
      check("t3_order", ids[k], k);
      check("t3_digits", hs[k]*100 + ts[k]*10 + os[k],
            exp4[k][0]*100 + exp4[k][1]*10 + exp4[k][2]);
      if (k > 0) check("t3_spacing", ats[k] - ats[k-1], 10);
    end

    // Round-robin after grant 2: client 3 beats client 0.
    set_data(2, 7); req[2] = 1'b1;
    wait_ack(id, at, h, t, o);
    check("t4_first", id, 2);
    set_data(0, 1); set_data(3, 2); req[0] = 1'b1; req[3] = 1'b1;
    wait_ack(id, at, h, t, o);
    check("t4_rr3", id, 3);
    wait_ack(id, at, h, t, o);
    check("t4_rr0", id, 0);

    // Reset during the fourth shift, then re-grant.
    @(negedge clk); #2 set_data(1, 123); req[1] = 1'b1;
    wait_busy();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", int'(busy), 0);
    check("t5_ack", int'(ack), 0);
    check("t5_digits", int'({hundreds, tens, ones}), 0);
    @(negedge clk); #2 rst = 1'b0;
    wait_ack(id, at, h, t, o);
    check("t5_regrant", id, 1);
`ifdef SCALE_5_8_EN
    check("t5_value", h*100 + t*10 + o, 76);
`else
    check("t5_value", h*100 + t*10 + o, 123);
`endif

    // Request dropped and data changed mid-conversion.
    @(negedge clk); #2 set_data(1, 200); req[1] = 1'b1;
    wait_busy();
    repeat (3) @(negedge clk);
    #2 req[1] = 1'b0; set_data(1, 55);
    wait_ack(id, at, h, t, o);
    check("t6_id", id, 1);
`ifdef SCALE_5_8_EN
    check("t6_value", h*100 + t*10 + o, 125);
`else
    check("t6_value", h*100 + t*10 + o, 200);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #2;
      for (int i = 0; i < N; i++) begin
        int v;
        v = $urandom_range(255);
        if ($urandom_range(7) == 0) v = ($urandom_range(1) == 1) ? 255 : 0;
        if (req[i] && ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1; set_data(i, v);
        end else if ($urandom_range(40) == 0) req[i] = 1'b0;
        if ($urandom_range(10) == 0) set_data(i, $urandom_range(255));
      end
      if ($urandom_range(400) == 0) begin
        rst = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
      end
    end

    req = '0;
    repeat (12) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
